// File: rtl/timekeeper_core_if.sv
// Timekeeper control/status bundle.
// master drives controls, slave is the core.
interface timekeeper_core_if;
  logic       run;
  logic       mode_12h;
  logic       set_en;
  logic [1:0] set_field;
  logic       inc;
  logic       dec;
  logic       alarm_en;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_minute;
  logic       alarm_ack;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [4:0] disp_hour;
  logic       pm;
  logic       sec_tick;
  logic       alarm_pulse;
  logic       alarm_active;

  modport master (
    output run, mode_12h, set_en, set_field,
    output inc, dec, alarm_en, alarm_hour,
    output alarm_minute, alarm_ack,
    input  hour, minute, second, disp_hour,
    input  pm, sec_tick, alarm_pulse, alarm_active
  );

  modport slave (
    input  run, mode_12h, set_en, set_field,
    input  inc, dec, alarm_en, alarm_hour,
    input  alarm_minute, alarm_ack,
    output hour, minute, second, disp_hour,
    output pm, sec_tick, alarm_pulse, alarm_active
  );
endinterface

// File: rtl/timekeeper_core.sv
// Time-of-day counter with set mode, 12/24h
// display and a minute-resolution alarm.
module timekeeper_core #(
  parameter int unsigned TICKS_PER_SEC = 65536,
  parameter int unsigned PRESC_W       = 16
) (
  input logic              clock,
  input logic              reset,
  timekeeper_core_if.slave tk
);
  typedef enum logic {S_RUN, S_SET} state_e;

  localparam logic [PRESC_W-1:0] LAST =
    PRESC_W'(TICKS_PER_SEC - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [4:0]         hour_q, hour_d;
  logic [5:0]         min_q, min_d;
  logic [5:0]         sec_q, sec_d;
  logic               tick_q, tick_d;
  logic               pulse_q, pulse_d;
  logic               active_q, active_d;

  logic       count_en, sec_evt, edit;
  logic [4:0] hr_inc, hr_dec;
  logic [5:0] min_inc, min_dec;
  logic [5:0] sec_inc, sec_dec;
  logic [4:0] disp_d;
  logic       pm_d;

  always_comb begin
    sec_inc = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    sec_dec = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
    min_inc = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    min_dec = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
    hr_inc  = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
    hr_dec  = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
  end

  always_comb begin
    state_d  = tk.set_en ? S_SET : S_RUN;
    presc_d  = presc_q;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    tick_d   = 1'b0;
    pulse_d  = 1'b0;
    count_en = tk.run && !tk.set_en;
    // no second may complete on the SET exit edge
    sec_evt  = count_en && (state_q == S_RUN)
               && (presc_q == LAST);
    edit     = tk.set_en && (tk.inc ^ tk.dec);
    if ((state_q == S_SET) && !tk.set_en) begin
      presc_d = '0;
    end else if (count_en) begin
      presc_d = sec_evt ? '0 : presc_q + PRESC_W'(1);
    end
    if (sec_evt) begin
      tick_d = 1'b1;
      sec_d  = sec_inc;
      if (sec_q == 6'd59) begin
        min_d = min_inc;
        if (min_q == 6'd59) begin
          hour_d = hr_inc;
        end
      end
      pulse_d = tk.alarm_en && (sec_d == 6'd0)
                && (min_d == tk.alarm_minute)
                && (hour_d == tk.alarm_hour);
    end else if (edit) begin
      unique case (1'b1)
        tk.set_field == 2'd0:
          sec_d = tk.inc ? sec_inc : sec_dec;
        tk.set_field == 2'd1:
          min_d = tk.inc ? min_inc : min_dec;
        tk.set_field == 2'd2:
          hour_d = tk.inc ? hr_inc : hr_dec;
        default: ;
      endcase
    end
    // set wins over ack through the whole pulse
    if (pulse_d || pulse_q) begin
      active_d = 1'b1;
    end else if (tk.alarm_ack || !tk.alarm_en) begin
      active_d = 1'b0;
    end else begin
      active_d = active_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RUN;
      presc_q  <= '0;
      hour_q   <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      tick_q   <= 1'b0;
      pulse_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      tick_q   <= tick_d;
      pulse_q  <= pulse_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    disp_d = hour_q;
    pm_d   = 1'b0;
    if (tk.mode_12h) begin
      pm_d = (hour_q >= 5'd12);
      if ((hour_q == 5'd0) || (hour_q == 5'd12)) begin
        disp_d = 5'd12;
      end else if (hour_q > 5'd12) begin
        disp_d = hour_q - 5'd12;
      end
    end
  end

  assign tk.hour         = hour_q;
  assign tk.minute       = min_q;
  assign tk.second       = sec_q;
  assign tk.disp_hour    = disp_d;
  assign tk.pm           = pm_d;
  assign tk.sec_tick     = tick_q;
  assign tk.alarm_pulse  = pulse_q;
  assign tk.alarm_active = active_q;
endmodule

// File: doc/timekeeper_core.md
TIMEKEEPER_CORE -- requirements
Module: timekeeper_core

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 65536: clock cycles per second; legal range 2..2^24.
REQ-002 SHALL have parameter PRESC_W, default 16: prescaler width; must satisfy 2^PRESC_W >= TICKS_PER_SEC.
REQ-003 SHALL have port clock, input, 1: system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port run, input, 1: 1 = timekeeping advances; 0 = prescaler and time frozen.
REQ-006 SHALL have port mode_12h, input, 1: 1 = 12-hour display, 0 = 24-hour display.
REQ-007 SHALL have port set_en, input, 1: 1 = set mode (edit time, counting suspended).
REQ-008 SHALL have port set_field, input, 2: field to edit; 0 = seconds, 1 = minutes, 2 = hours, 3 = none.
REQ-009 SHALL have port inc, input, 1: single-cycle pulse, increment the selected field.
REQ-010 SHALL have port dec, input, 1: single-cycle pulse, decrement the selected field.
REQ-011 SHALL have port alarm_en, input, 1: alarm armed.
REQ-012 SHALL have port alarm_hour, input, 5: alarm hour, 0..23.
REQ-013 SHALL have port alarm_minute, input, 6: alarm minute, 0..59.
REQ-014 SHALL have port alarm_ack, input, 1: clears alarm_active.
REQ-015 SHALL have port hour, output, 5: binary hour 0..23.
REQ-016 SHALL have port minute, output, 6: binary minute 0..59.
REQ-017 SHALL have port second, output, 6: binary second 0..59.
REQ-018 SHALL have port disp_hour, output, 5: display hour.
REQ-019 SHALL have port pm, output, 1: PM indicator.
REQ-020 SHALL have port sec_tick, output, 1: one-cycle pulse per counted second.
REQ-021 SHALL have port alarm_pulse, output, 1: one-cycle alarm strobe.
REQ-022 SHALL have port alarm_active, output, 1: sticky alarm flag.

Function
REQ-023 SHALL run a prescaler counting 0..TICKS_PER_SEC-1 while run=1 and set_en=0; at TICKS_PER_SEC-1 it wraps to 0 on the next edge, producing a second event.
REQ-024 SHALL, on a second event, advance second by 1 on the same edge, drive sec_tick high for exactly the following cycle, and hold the prescaler when run=0 or set_en=1.
REQ-025 SHALL wrap second 59->0 with a minute carry, wrap minute 59->0 with an hour carry, and wrap hour 23->0, with all carries applied on the same edge (23:59:59 -> 00:00:00 in one cycle).
REQ-026 SHALL implement a two-state FSM: RUN (set_en=0) and SET (set_en=1), switching on the edge where set_en is sampled changed.
REQ-027 SHALL, in SET, apply inc/dec to the set_field field only, with modulo wrap (seconds and minutes 0..59, hours 0..23) and no carry to other fields; set_field=3 ignores inc/dec.
REQ-028 SHALL ignore inc and dec when both are high in the same cycle, and ignore both in RUN.
REQ-029 SHALL clear the prescaler to 0 on the SET->RUN transition so the first second after leaving SET takes a full TICKS_PER_SEC cycles.
REQ-030 SHALL, when mode_12h=1, drive disp_hour = 12 for hour 0 or 12, hour-12 for hour 13..23, hour otherwise, and pm = (hour >= 12).
REQ-031 SHALL, when mode_12h=0, drive disp_hour = hour and pm = 0; disp_hour and pm are combinational from hour and mode_12h.
REQ-032 SHALL assert alarm_pulse for one cycle, in the same cycle as sec_tick, when a second event produces second=0, minute=alarm_minute and hour=alarm_hour while alarm_en=1.
REQ-033 SHALL set alarm_active on alarm_pulse and keep it set until alarm_ack=1 or alarm_en=0; if alarm_pulse and alarm_ack coincide, alarm_active SHALL be set.
REQ-034 SHALL NOT generate alarm_pulse from SET-mode edits, even when the edited time matches the alarm.

Reset
REQ-035 SHALL, on reset low, asynchronously clear the prescaler, hour, minute, second, sec_tick, alarm_pulse and alarm_active to 0 and enter RUN, regardless of clock.
REQ-036 SHALL resume counting from 00:00:00 with a full TICKS_PER_SEC period after reset deasserts; reset asserted mid-SET or mid-carry SHALL leave no partial update.

Verification
REQ-037 SHALL cover rollover: TICKS_PER_SEC=4, preset 23:59:59 via SET -> after 4 RUN cycles hour=0, minute=0, second=0 and sec_tick=1 for one cycle.
REQ-038 SHALL cover set mode: set_field=1, minute=0, one dec pulse -> minute=59 and hour unchanged; inc+dec together -> no change; prescaler frozen throughout.
REQ-039 SHALL cover 12-hour display: hour=0 -> disp_hour=12, pm=0; hour=12 -> 12, pm=1; hour=15 -> 3, pm=1; mode_12h=0 with hour=15 -> 15, pm=0.
REQ-040 SHALL cover the alarm: alarm 07:30, alarm_en=1, time 07:29:59 -> alarm_pulse one cycle with sec_tick, alarm_active held until alarm_ack; SET to 07:30:00 -> no pulse.
REQ-041 SHALL cover run gating: run=0 for 10 cycles mid-second -> prescaler and time unchanged, and the second completes after the remaining cycles once run=1.
REQ-042 SHALL cover async reset: reset low between clock edges at 12:34:56 with alarm_active=1 -> all outputs 0 immediately, and first sec_tick exactly TICKS_PER_SEC cycles after release.
